// File: rtl/fsm.sv
// Menu-driven 8-bit calculator controller.
// Four pushbuttons walk a two-level operation tree. The selected operation
// is applied continuously to operands a and b. The 16-bit result drives led.
module fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic        bu,
    input  logic        br,
    input  logic        bd,
    input  logic        bl,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] led
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_ADD  = 4'd1,
        S_SUB  = 4'd2,
        S_MUL  = 4'd3,
        S_DIV  = 4'd4,
        S_RSH  = 4'd5,
        S_LSH  = 4'd6,
        S_OR   = 4'd7,
        S_AND  = 4'd8
    } state_t;

    // Button bit positions within the packed button vector.
    localparam int BTN_UP    = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 3;

    logic [3:0] btn;
    logic [3:0] btn_q;
    logic [3:0] press;
    logic       single_press;
    state_t     state_reg;

    assign btn = {bl, bd, br, bu};

    // One history flop per button. A press is a rising level seen at an edge.
    // Moving directly from one button to another therefore still registers
    // a press of the new button.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            // Remember last cycle's level so a held button counts only once.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    btn_q[gi] <= 1'b0;
                end else begin
                    btn_q[gi] <= btn[gi];
                end
            end
            assign press[gi] = btn[gi] & ~btn_q[gi];
        end
    endgenerate

    // Exactly one new press this cycle. Simultaneous presses are ambiguous
    // and are dropped as a group.
    assign single_press = (press != 4'd0) && ((press & (press - 4'd1)) == 4'd0);

    // Menu state machine. Terminal operations are held until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else if (single_press) begin
            case (state_reg)
                S_IDLE: begin
                    if (press[BTN_UP])         state_reg <= S_ADD;
                    else if (press[BTN_RIGHT]) state_reg <= S_SUB;
                    else if (press[BTN_DOWN])  state_reg <= S_MUL;
                    else                       state_reg <= S_DIV;
                end
                S_ADD: begin
                    if (press[BTN_RIGHT])      state_reg <= S_RSH;
                    else if (press[BTN_DOWN])  state_reg <= S_OR;
                    else if (press[BTN_LEFT])  state_reg <= S_LSH;
                end
                S_MUL: begin
                    if (press[BTN_UP])         state_reg <= S_AND;
                end
                default: state_reg <= state_reg;
            endcase
        end
    end

    logic [15:0] a_ext;
    logic [15:0] b_ext;
    logic [7:0]  quotient;

    assign a_ext = {8'h00, a};
    assign b_ext = {8'h00, b};
    // Divide by zero is guarded here; the DIV result substitutes all-ones.
    assign quotient = (b == 8'h00) ? 8'h00 : (a / b);

    // Result mux: purely combinational, so operand changes show immediately.
    always_comb begin
        led = 16'h0000;
        case (state_reg)
            S_IDLE: led = 16'h0000;
            S_ADD:  led = a_ext + b_ext;
            S_SUB:  led = a_ext - b_ext;
            S_MUL:  led = a_ext * b_ext;
            S_DIV:  led = (b == 8'h00) ? 16'hFFFF : {8'h00, quotient};
            S_RSH:  led = a_ext >> b[3:0];
            S_LSH:  led = a_ext << b[3:0];
            S_OR:   led = a_ext | b_ext;
            S_AND:  led = a_ext & b_ext;
            default: led = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_fsm.sv
// Directed bench for the calculator menu controller.
module tb_fsm;

    logic        clk;
    logic        reset;
    logic        bu, br, bd, bl;
    logic [7:0]  a, b;
    logic [15:0] led;

    int n_assert = 0;
    int n_fail   = 0;

    fsm dut (
        .clk   (clk),
        .reset (reset),
        .bu    (bu),
        .br    (br),
        .bd    (bd),
        .bl    (bl),
        .a     (a),
        .b     (b),
        .led   (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] exp);
        n_assert++;
        assert (led === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, led, exp);
        end
    endtask

    // Buttons as {left, down, right, up}; applied at negedge, sampled after posedge.
    task automatic step(input logic [3:0] btns);
        @(negedge clk);
        {bl, bd, br, bu} = btns;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        {bl, bd, br, bu} = 4'b0000;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    localparam logic [3:0] UP = 4'b0001, RT = 4'b0010, DN = 4'b0100, LT = 4'b1000, NONE = 4'b0000;

    initial begin
        reset = 1'b0;
        {bl, bd, br, bu} = 4'b0000;
        a = 8'd12;
        b = 8'd24;
        #2;
        check("reset_led", 16'h0000);
        #20;
        reset = 1'b1;
        step(NONE);
        check("idle_after_reset", 16'h0000);

        // ADD, then hold up
        step(UP);   check("add", 16'h0024);
        step(UP);   check("add_hold1", 16'h0024);
        step(UP);   check("add_hold2", 16'h0024);
        step(UP);   check("add_hold3", 16'h0024);
        // combinational operand update
        @(negedge clk); a = 8'd1; b = 8'd2; #1;
        check("add_comb", 16'h0003);
        a = 8'd12; b = 8'd24;

        do_reset(); step(RT); check("sub", 16'hFFF4);
        step(NONE); step(UP);  check("sub_up", 16'hFFF4);
        step(NONE); step(DN);  check("sub_down", 16'hFFF4);
        step(NONE); step(LT);  check("sub_left", 16'hFFF4);

        do_reset(); step(DN); check("mul", 16'h0120);

        do_reset(); step(LT); check("div", 16'h0000);
        @(negedge clk); a = 8'd48; #1; check("div_48_24", 16'h0002);
        a = 8'd200; b = 8'd0;
        do_reset(); step(LT); check("div_by_zero", 16'hFFFF);
        a = 8'd12; b = 8'd24;

        do_reset(); step(UP); step(RT); check("rsh", 16'h0000);
        @(negedge clk); a = 8'hF0; b = 8'd4; #1; check("rsh_f0_4", 16'h000F);
        a = 8'd12; b = 8'd24;

        do_reset(); step(UP); step(LT); check("lsh", 16'h0C00);
        do_reset(); step(UP); step(DN); check("or", 16'h001C);
        do_reset(); step(DN); step(UP); check("and", 16'h0008);
        do_reset(); step(DN); step(RT); check("mul_right_ignored", 16'h0120);

        // simultaneous presses from IDLE are dropped
        do_reset(); step(UP | RT); check("idle_multi", 16'h0000);
        step(NONE); step(DN); check("idle_multi_then_down", 16'h0120);

        // asynchronous reset mid-operation
        do_reset(); step(DN); check("mul_pre_reset", 16'h0120);
        @(negedge clk); {bl, bd, br, bu} = NONE;
        #2; reset = 1'b0; #1;
        check("async_reset", 16'h0000);
        @(negedge clk); reset = 1'b1;
        step(NONE); check("idle_after_async", 16'h0000);
        step(UP);   check("idle_then_up", 16'h0024);

        // button held through reset release counts as a press
        @(negedge clk); reset = 1'b0; bu = 1'b1;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("held_through_reset", 16'h0024);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
